// File: rtl/lcd_msg_ctrl.sv
// lcd_msg_ctrl: parametrised HD44780 character-LCD controller.
// Runs the power-on init sequence (0x38, 0x0C, 0x06, 0x01), then redraws a
// ROWS x COLS screen from an external message ROM whenever a message is
// requested. Requests that arrive while busy collapse into one follow-up
// redraw of the most recent selection.
// Optional feature macro: LCD_REFRESH_EN adds a periodic auto-redraw of the
// current message after REFRESH_CYC idle cycles.
module lcd_msg_ctrl #(
    parameter int COLS          = 16,
    parameter int ROWS          = 2,
    parameter int MSG_W         = 4,
    parameter int EN_HIGH_CYC   = 16,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int CLR_WAIT_CYC  = 80000,
    parameter int INIT_WAIT_CYC = 750000,
    parameter int REFRESH_CYC   = 2500000,
    // Field widths are floored at 1 so a single row/column still has an address bit.
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   iCLK,
    input  logic                   iRST_N,
    input  logic [MSG_W-1:0]       iMSG_SEL,
    input  logic                   iMSG_VLD,
    output logic                   oBUSY,
    output logic                   oINIT_DONE,
    output logic [MSG_W+RW+CW-1:0] oCHAR_ADDR,
    input  logic [7:0]             iCHAR_DATA,
    output logic [7:0]             LCD_DATA,
    output logic                   LCD_RW,
    output logic                   LCD_EN,
    output logic                   LCD_RS
);

    localparam int MAX_A   = (INIT_WAIT_CYC > CLR_WAIT_CYC) ? INIT_WAIT_CYC : CLR_WAIT_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > EN_HIGH_CYC) ? CMD_WAIT_CYC : EN_HIGH_CYC;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        S_INIT_WAIT, S_INIT_CMD, S_IDLE, S_SET_ADDR, S_FETCH, S_WRITE_CHR
    } state_t;

    // Every LCD write walks SETUP (bus valid, EN low) -> HIGH -> WAIT.
    typedef enum logic [1:0] { PH_SETUP, PH_HIGH, PH_WAIT } phase_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    return 8'h0C;   // display on, cursor off
            2'd2:    return 8'h06;   // auto-increment, no shift
            default: return 8'h01;   // clear display
        endcase
    endfunction

    // Set-DDRAM-address command for the start of a row.
    function automatic logic [7:0] row_cmd(input logic [RW-1:0] r);
        case (int'(r))
            0:       return 8'h80;
            1:       return 8'hC0;
            2:       return 8'h94;
            default: return 8'hD4;
        endcase
    endfunction

    state_t                   state_q, state_d;
    phase_t                   phase_q, phase_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               init_idx_q, init_idx_d;
    logic [RW-1:0]            row_q, row_d, row_inc;
    logic [CW-1:0]            col_q, col_d, col_inc;
    logic [MSG_W-1:0]         cur_msg_q, cur_msg_d;
    logic                     pend_q, pend_d;
    logic [MSG_W-1:0]         pend_msg_q, pend_msg_d;
    logic [MSG_W+RW+CW-1:0]   addr_q, addr_d;
    logic [7:0]               data_q, data_d;
    logic                     rs_q, rs_d;
    logic                     en_q, en_d;
    logic                     init_done_q, init_done_d;

    logic                     xfer_done;
    logic                     redraw_go;
    logic                     ld_xfer;
    logic                     ld_rs;
    logic [7:0]               ld_data;
    logic [CNT_W-1:0]         wait_last;

    assign row_inc = row_q + RW'(1);
    assign col_inc = col_q + CW'(1);

`ifdef LCD_REFRESH_EN
    localparam int RF_W = $clog2(REFRESH_CYC + 1);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYC - 1);
    logic [RF_W-1:0] refresh_q;

    // Idle-time counter; held at zero whenever a redraw or init is running.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)                                  refresh_q <= '0;
        else if (state_q != S_IDLE || refresh_q == RF_LAST) refresh_q <= '0;
        else                                          refresh_q <= refresh_q + RF_W'(1);
    end
`endif

    // State register plus all registered LCD/ROM-side outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_INIT_WAIT;
            phase_q     <= PH_SETUP;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cur_msg_q   <= '0;
            pend_q      <= 1'b0;
            pend_msg_q  <= '0;
            addr_q      <= '0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples the pre-edge
            // values computed by the combinational block, independent of order.
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cur_msg_q   <= cur_msg_d;
            pend_q      <= pend_d;
            pend_msg_q  <= pend_msg_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            init_done_q <= init_done_d;
        end
    end

    // Next-state logic: transfer sequencing, screen walk and request handling.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a variable unassigned and infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        row_d       = row_q;
        col_d       = col_q;
        cur_msg_d   = cur_msg_q;
        pend_d      = pend_q;
        pend_msg_d  = pend_msg_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rs_d        = rs_q;
        en_d        = en_q;
        init_done_d = init_done_q;
        xfer_done   = 1'b0;
        redraw_go   = 1'b0;
        ld_xfer     = 1'b0;
        ld_rs       = 1'b0;
        ld_data     = 8'h00;

        // The clear command needs the long settle time; all else the short one.
        wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

        if (state_q inside {S_INIT_CMD, S_SET_ADDR, S_WRITE_CHR}) begin
            case (phase_q)
                PH_SETUP: begin
                    en_d    = 1'b1;
                    phase_d = PH_HIGH;
                    cnt_d   = '0;
                end
                PH_HIGH: begin
                    if (cnt_q == EN_LAST) begin
                        en_d    = 1'b0;
                        phase_d = PH_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_WAIT: begin
                    if (cnt_q == wait_last) xfer_done = 1'b1;
                    else                    cnt_d = cnt_q + CNT_W'(1);
                end
                default: phase_d = PH_SETUP;
            endcase
        end

        // Requests while busy collapse into one pending redraw of the latest value.
        if (iMSG_VLD && state_q != S_IDLE) begin
            pend_d     = 1'b1;
            pend_msg_d = iMSG_SEL;
        end

        case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d    = S_INIT_CMD;
                    init_idx_d = 2'd0;
                    ld_xfer    = 1'b1;
                    ld_data    = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_INIT_CMD: begin
                if (xfer_done) begin
                    if (init_idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        redraw_go   = 1'b1;   // first screen needs no request
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        ld_xfer    = 1'b1;
                        ld_data    = init_cmd(init_idx_q + 2'd1);
                    end
                end
            end
            S_IDLE: begin
                if (iMSG_VLD) redraw_go = 1'b1;
`ifdef LCD_REFRESH_EN
                else if (refresh_q == RF_LAST) redraw_go = 1'b1;
`endif
            end
            S_SET_ADDR: begin
                if (xfer_done) begin
                    state_d = S_FETCH;
                    addr_d  = {cur_msg_q, row_q, col_q};
                end
            end
            S_FETCH: begin
                // ROM byte for the address presented this cycle is captured here.
                state_d = S_WRITE_CHR;
                ld_xfer = 1'b1;
                ld_rs   = 1'b1;
                ld_data = iCHAR_DATA;
            end
            S_WRITE_CHR: begin
                if (xfer_done) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d = '0;
                            if (iMSG_VLD || pend_q) redraw_go = 1'b1;
                            else                    state_d   = S_IDLE;
                        end else begin
                            row_d   = row_inc;
                            state_d = S_SET_ADDR;
                            ld_xfer = 1'b1;
                            ld_data = row_cmd(row_inc);
                        end
                    end else begin
                        col_d   = col_inc;
                        state_d = S_FETCH;
                        addr_d  = {cur_msg_q, row_q, col_inc};
                    end
                end
            end
            default: state_d = S_INIT_WAIT;
        endcase

        // Redraw start: latest request wins, then pending, else keep current msg.
        if (redraw_go) begin
            state_d = S_SET_ADDR;
            row_d   = '0;
            col_d   = '0;
            pend_d  = 1'b0;
            if (iMSG_VLD)    cur_msg_d = iMSG_SEL;
            else if (pend_q) cur_msg_d = pend_msg_q;
            ld_xfer = 1'b1;
            ld_data = row_cmd('0);
        end

        if (ld_xfer) begin
            data_d  = ld_data;
            rs_d    = ld_rs;
            en_d    = 1'b0;
            phase_d = PH_SETUP;
            cnt_d   = '0;
        end
    end

    assign oBUSY      = (state_q != S_IDLE);
    assign oINIT_DONE = init_done_q;
    assign oCHAR_ADDR = addr_q;
    assign LCD_DATA   = data_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;
    assign LCD_RS     = rs_q;

endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// tb_lcd_msg_ctrl: directed bench for lcd_msg_ctrl with a 2x4 screen and short
// timing. A combinational model ROM returns 'A'+col. A negedge monitor logs every
// EN pulse (data, RS, msg field, rise/fall cycle) and every oCHAR_ADDR change.
module tb_lcd_msg_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int MSG_W = 4;
    localparam int AW = 7;

    logic             iCLK = 1'b0;
    logic             iRST_N = 1'b0;
    logic [MSG_W-1:0] iMSG_SEL = '0;
    logic             iMSG_VLD = 1'b0;
    logic             oBUSY;
    logic             oINIT_DONE;
    logic [AW-1:0]    oCHAR_ADDR;
    logic [7:0]       iCHAR_DATA;
    logic [7:0]       LCD_DATA;
    logic             LCD_RW;
    logic             LCD_EN;
    logic             LCD_RS;

    always #5 iCLK = ~iCLK;

    lcd_msg_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .MSG_W(MSG_W), .EN_HIGH_CYC(2), .CMD_WAIT_CYC(3),
        .CLR_WAIT_CYC(5), .INIT_WAIT_CYC(10), .REFRESH_CYC(200)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iMSG_SEL(iMSG_SEL), .iMSG_VLD(iMSG_VLD),
        .oBUSY(oBUSY), .oINIT_DONE(oINIT_DONE), .oCHAR_ADDR(oCHAR_ADDR),
        .iCHAR_DATA(iCHAR_DATA), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS)
    );

    // Model ROM: character = 'A' + column, independent of msg and row.
    assign iCHAR_DATA = 8'h41 + {6'd0, oCHAR_ADDR[1:0]};

    int         cyc = 0;
    bit         prev_en = 1'b0;
    bit         prev_done = 1'b0;
    int         rise_c = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0] p_data[$];
    logic       p_rs[$];
    logic [3:0] p_msg[$];
    int         p_len[$];
    int         p_rise[$];
    int         p_fall[$];
    logic [AW-1:0] a_log[$];
    int         d_log[$];

    always @(negedge iCLK) begin
        cyc++;
        if (LCD_EN && !prev_en) begin
            p_data.push_back(LCD_DATA);
            p_rs.push_back(LCD_RS);
            p_msg.push_back(oCHAR_ADDR[6:3]);
            p_rise.push_back(cyc);
            rise_c = cyc;
        end
        if (!LCD_EN && prev_en) begin
            p_len.push_back(cyc - rise_c);
            p_fall.push_back(cyc);
        end
        prev_en = LCD_EN;
        if (oCHAR_ADDR != prev_addr) a_log.push_back(oCHAR_ADDR);
        prev_addr = oCHAR_ADDR;
        if (oINIT_DONE && !prev_done) d_log.push_back(cyc);
        prev_done = oINIT_DONE;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge iCLK);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (oBUSY && n < budget) begin
            step();
            n++;
        end
        check(tag, oBUSY, 1'b0);
    endtask

    task automatic request(input logic [MSG_W-1:0] sel);
        iMSG_SEL = sel;
        iMSG_VLD = 1'b1;
        step();
        iMSG_VLD = 1'b0;
    endtask

    function automatic int count_msg(input int from, input logic [3:0] m);
        int c = 0;
        for (int i = from; i < a_log.size(); i++)
            if (a_log[i][6:3] == m) c++;
        return c;
    endfunction

    initial begin
        logic [7:0] init_seq [4];
        logic [7:0] scr_data [10];
        logic       scr_rs [10];
        int rel, b, ab, n;

        init_seq = '{8'h38, 8'h0C, 8'h06, 8'h01};
        scr_data = '{8'h80, 8'h41, 8'h42, 8'h43, 8'h44, 8'hC0, 8'h41, 8'h42, 8'h43, 8'h44};
        scr_rs   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state.
        repeat (3) step();
        check("rst_en", LCD_EN, 1'b0);
        check("rst_rs", LCD_RS, 1'b0);
        check("rst_rw", LCD_RW, 1'b0);
        check("rst_data", LCD_DATA, 8'h00);
        check("rst_addr", oCHAR_ADDR, '0);
        check("rst_init_done", oINIT_DONE, 1'b0);
        check("rst_busy", oBUSY, 1'b1);

        // 1: init sequence after reset release.
        rel = cyc;
        iRST_N = 1'b1;
        wait_idle(400, "init_timeout");
        check("init_first_rise", p_rise[0] - rel, 11);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("init_cmd%0d", i), p_data[i], init_seq[i]);
            check($sformatf("init_rs%0d", i), p_rs[i], 1'b0);
            check($sformatf("init_en_len%0d", i), p_len[i], 2);
        end
        check("cmd_gap", p_rise[1] - p_fall[0], 4);
        check("clr_gap_to_done", d_log[0] - p_fall[3], 5);
        check("init_done", oINIT_DONE, 1'b1);

        // 2: post-init redraw of msg 0.
        check("post_init_pulses", p_data.size(), 14);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("scr0_data%0d", i), p_data[4 + i], scr_data[i]);
            check($sformatf("scr0_rs%0d", i), p_rs[4 + i], scr_rs[i]);
        end
        check("scr0_msg", p_msg[13], 4'd0);

        // 3: request msg 5 while idle.
        b = p_data.size();
        ab = a_log.size();
        request(4'd5);
        check("req_busy_next", oBUSY, 1'b1);
        wait_idle(400, "req5_timeout");
        check("req5_pulses", p_data.size() - b, 10);
        check("req5_fetches", a_log.size() - ab, 8);
        check("req5_msg_fetches", count_msg(ab, 4'd5), 8);
        check("req5_row0_cmd", p_data[b], 8'h80);
        check("req5_row1_cmd", p_data[b + 5], 8'hC0);

        // 4: two requests during a redraw collapse to one redraw of the latest.
        b = p_data.size();
        ab = a_log.size();
        request(4'd2);
        repeat (15) step();
        request(4'd3);
        repeat (10) step();
        request(4'd7);
        wait_idle(800, "collapse_timeout");
        check("collapse_pulses", p_data.size() - b, 20);
        check("collapse_msg2", count_msg(ab, 4'd2), 8);
        check("collapse_msg7", count_msg(ab, 4'd7), 8);
        check("collapse_msg3", count_msg(ab, 4'd3), 0);

        // 6: idle behaviour with and without auto refresh.
        b = p_data.size();
        ab = a_log.size();
`ifdef LCD_REFRESH_EN
        n = 0;
        while (!oBUSY && n < 400) begin
            n++;
            step();
        end
        check("refresh_idle_cycles", n, 200);
        wait_idle(400, "refresh_timeout");
        check("refresh_pulses", p_data.size() - b, 10);
        check("refresh_msg7", count_msg(ab, 4'd7), 8);
`else
        repeat (300) step();
        check("no_refresh_pulses", p_data.size() - b, 0);
        check("no_refresh_busy", oBUSY, 1'b0);
`endif

        // 5: reset while EN is high during a character write.
        request(4'd1);
        n = 0;
        while (!(LCD_EN && LCD_RS) && n < 200) begin
            step();
            n++;
        end
        check("found_chr_en", {LCD_EN, LCD_RS}, 2'b11);
        iRST_N = 1'b0;
        #1;
        check("midrst_en", LCD_EN, 1'b0);
        check("midrst_init_done", oINIT_DONE, 1'b0);
        check("midrst_busy", oBUSY, 1'b1);
        check("midrst_addr", oCHAR_ADDR, '0);
        step();
        b = p_data.size();
        n = d_log.size();
        rel = cyc;
        iRST_N = 1'b1;
        wait_idle(400, "reinit_timeout");
        check("reinit_first_rise", p_rise[b] - rel, 11);
        for (int i = 0; i < 4; i++)
            check($sformatf("reinit_cmd%0d", i), p_data[b + i], init_seq[i]);
        check("reinit_pulses", p_data.size() - b, 14);
        check("reinit_row0_cmd", p_data[b + 4], 8'h80);
        check("reinit_msg0", p_msg[b + 5], 4'd0);
        check("reinit_done_events", d_log.size() - n, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
